// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, majority-vote sample placement
// and the parity-type encoding used by both Tx and Rx.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    // Majority samples sit one oversample tick either side of mid-bit.
    localparam int unsigned MAJ_EARLY_OFS = 1;
    localparam int unsigned MAJ_LATE_OFS  = 1;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    function automatic int unsigned mid_point(input int unsigned ovs);
        return ovs / 2;
    endfunction

endpackage

// File: rtl/rx_bit_sampler.sv
// Serial-line front end: 2-flop synchronizer, oversample counter and a
// 3-sample majority vote around mid-bit.
module rx_bit_sampler
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic hard_rst_n,
    input  logic baud_tick,
    input  logic rx_in,
    input  logic restart,
    output logic rx_s,
    output logic bit_done,
    output logic bit_val,
    output logic period_end
);

    localparam int unsigned CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] IDX_LO  = CW'(mid_point(OVERSAMPLE) - MAJ_EARLY_OFS);
    localparam logic [CW-1:0] IDX_MID = CW'(mid_point(OVERSAMPLE));
    localparam logic [CW-1:0] IDX_HI  = CW'(mid_point(OVERSAMPLE) + MAJ_LATE_OFS);

    logic          sync1;
    logic [CW-1:0] scnt;
    logic          s_lo;
    logic          s_mid;

    always_ff @(posedge clk) begin
        if (!hard_rst_n) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
            scnt  <= '0;
            s_lo  <= 1'b1;
            s_mid <= 1'b1;
        end else begin
            sync1 <= rx_in;
            rx_s  <= sync1;
            if (baud_tick) begin
                if (restart) begin
                    scnt <= '0;
                end else begin
                    scnt <= scnt + 1'b1;
                end
                if (scnt == IDX_LO) begin
                    s_lo <= rx_s;
                end
                if (scnt == IDX_MID) begin
                    s_mid <= rx_s;
                end
            end
        end
    end

    // Third sample is the live synchronized value on the deciding tick.
    always_comb begin
        bit_done   = baud_tick && (scnt == IDX_HI);
        bit_val    = (s_lo & s_mid) | (s_lo & rx_s) | (s_mid & rx_s);
        period_end = baud_tick && (scnt == '1);
    end

endmodule

// File: rtl/uart_rx_fsmd.sv
// UART receiver FSMD: start/data/parity/stop framing on top of the oversampled
// bit sampler, delivering a data_valid pulse with per-frame error flags.
module uart_rx_fsmd
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic                  clk,
    input  logic                  hard_rst_n,
    input  logic                  baud_tick,
    input  logic                  rx_in,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stop_err,
    output logic                  busy
);

    localparam int unsigned BW = $clog2(DATA_WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    rx_state_t             state;
    rx_state_t             state_next;
    logic [BW-1:0]         bcnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  par_en_l;
    logic                  par_typ_l;
    logic                  par_err_int;
    logic                  restart;
    logic                  rx_s;
    logic                  bit_done;
    logic                  bit_val;
    logic                  period_end;

    rx_bit_sampler #(
        .OVERSAMPLE(OVERSAMPLE)
    ) u_sampler (
        .clk       (clk),
        .hard_rst_n(hard_rst_n),
        .baud_tick (baud_tick),
        .rx_in     (rx_in),
        .restart   (restart),
        .rx_s      (rx_s),
        .bit_done  (bit_done),
        .bit_val   (bit_val),
        .period_end(period_end)
    );

    always_ff @(posedge clk) begin
        if (!hard_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (baud_tick && !rx_s) state_next = START;
            START: begin
                if (bit_done && bit_val) begin
                    state_next = IDLE;
                end else if (period_end) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (period_end && (bcnt == LAST_BIT)) begin
                    state_next = par_en_l ? PARITY : STOP;
                end
            end
            PARITY: if (period_end) state_next = STOP;
            STOP:   if (bit_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Any state change restarts the oversample count from zero.
    assign restart = (state_next != state);
    assign busy    = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!hard_rst_n) begin
            bcnt        <= '0;
            shreg       <= '0;
            par_en_l    <= 1'b0;
            par_typ_l   <= PAR_EVEN;
            par_err_int <= 1'b0;
            rx_data     <= '0;
            data_valid  <= 1'b0;
            par_err     <= 1'b0;
            stop_err    <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            if (state == IDLE && state_next == START) begin
                par_en_l    <= par_en;
                par_typ_l   <= par_typ;
                par_err_int <= 1'b0;
            end
            if (state == START && state_next == DATA) begin
                bcnt <= '0;
            end
            if (state == DATA) begin
                if (bit_done) begin
                    shreg <= {bit_val, shreg[DATA_WIDTH-1:1]};
                end
                if (period_end) begin
                    bcnt <= bcnt + 1'b1;
                end
            end
            if (state == PARITY && bit_done) begin
                par_err_int <= ((^shreg) ^ bit_val) != par_typ_l;
            end
            if (state == STOP && bit_done) begin
                rx_data    <= shreg;
                data_valid <= 1'b1;
                par_err    <= par_en_l ? par_err_int : 1'b0;
                stop_err   <= ~bit_val;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fsmd.sv
// Self-checking bench for uart_rx_fsmd: directed and random frames compared
// against a frame-level expectation queue.
module tb_uart_rx_fsmd;

    localparam int unsigned DW       = 8;
    localparam int unsigned OVS      = 16;
    localparam int unsigned TICK_DIV = 4;

    typedef struct {
        logic [DW-1:0] data;
        logic          pe;
        logic          se;
    } frame_t;

    logic          clk = 1'b0;
    logic          hard_rst_n = 1'b0;
    logic          baud_tick = 1'b0;
    logic          rx_in = 1'b1;
    logic          par_en = 1'b0;
    logic          par_typ = 1'b0;
    logic [DW-1:0] rx_data;
    logic          data_valid;
    logic          par_err;
    logic          stop_err;
    logic          busy;

    int            n_checks = 0;
    int            n_fail = 0;
    int            mode = 0;          // 0 = expect queue, 1 = break, 2 = ignore
    int            break_pulses = 0;
    int unsigned   div_cnt = 0;
    frame_t        exp_q[$];

    uart_rx_fsmd #(
        .DATA_WIDTH(DW),
        .OVERSAMPLE(OVS)
    ) dut (
        .clk       (clk),
        .hard_rst_n(hard_rst_n),
        .baud_tick (baud_tick),
        .rx_in     (rx_in),
        .par_en    (par_en),
        .par_typ   (par_typ),
        .rx_data   (rx_data),
        .data_valid(data_valid),
        .par_err   (par_err),
        .stop_err  (stop_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (div_cnt == TICK_DIV - 1) begin
            div_cnt   <= 0;
            baud_tick <= 1'b1;
        end else begin
            div_cnt   <= div_cnt + 1;
            baud_tick <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        frame_t f;
        if (hard_rst_n && data_valid) begin
            case (mode)
                0: begin
                    if (exp_q.size() == 0) begin
                        check("spurious_valid", 32'(1), 32'(0));
                    end else begin
                        f = exp_q.pop_front();
                        check("rx_data", 32'(rx_data), 32'(f.data));
                        check("par_err", 32'(par_err), 32'(f.pe));
                        check("stop_err", 32'(stop_err), 32'(f.se));
                        check("busy_after_valid", 32'(busy), 32'(0));
                    end
                end
                1: begin
                    break_pulses++;
                    check("break_data", 32'(rx_data), 32'(0));
                    check("break_stop_err", 32'(stop_err), 32'(1));
                end
                default: ;
            endcase
        end
    end

    // One line slot per baud tick; the new level follows the tick edge.
    task automatic put(input logic v);
        @(posedge clk iff baud_tick);
        #1;
        rx_in = v;
    endtask

    task automatic put_bit(input logic v, input int flip_slot);
        for (int s = 0; s < int'(OVS); s++) begin
            put((s == flip_slot) ? ~v : v);
        end
    endtask

    task automatic idle_bits(input int n);
        repeat (n * int'(OVS)) put(1'b1);
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input logic pen, input logic ptyp,
                              input logic flip_par, input logic stop_v, input int flip_bit);
        frame_t f;
        logic   pb;
        int     ones;
        pb   = (^d) ^ ptyp ^ flip_par;
        ones = $countones(d) + int'(pb);
        f.data = d;
        f.pe   = pen ? ((ones % 2) != int'(ptyp)) : 1'b0;
        f.se   = ~stop_v;
        exp_q.push_back(f);
        par_en  = pen;
        par_typ = ptyp;
        put_bit(1'b0, -1);
        for (int i = 0; i < int'(DW); i++) begin
            put_bit(d[i], (i == flip_bit) ? 9 : -1);
        end
        if (pen) put_bit(pb, -1);
        put_bit(stop_v, -1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] d;
        logic          sv;
        int            fb;
        int            gap;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rx_data", 32'(rx_data), 32'(0));
        check("rst_valid", 32'(data_valid), 32'(0));
        check("rst_par_err", 32'(par_err), 32'(0));
        check("rst_stop_err", 32'(stop_err), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        hard_rst_n = 1'b1;
        idle_bits(2);

        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        idle_bits(2);

        send_frame(8'h37, 1'b1, 1'b0, 1'b0, 1'b1, -1);
        idle_bits(1);
        send_frame(8'h37, 1'b1, 1'b0, 1'b1, 1'b1, -1);
        idle_bits(2);

        par_en = 1'b0;
        repeat (5) put(1'b0);
        idle_bits(2);
        check("glitch_busy", 32'(busy), 32'(0));

        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 3);
        idle_bits(1);

        send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        idle_bits(2);

        for (int n = 0; n < 24; n++) begin
            d   = DW'($urandom);
            sv  = ($urandom_range(0, 5) != 0);
            fb  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, DW - 1)) : -1;
            gap = int'($urandom_range(0, 2));
            if (!sv && gap == 0) gap = 1;
            send_frame(d, 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0), sv, fb);
            idle_bits(gap);
        end
        idle_bits(2);
        check("random_drained", 32'(exp_q.size()), 32'(0));

        par_en = 1'b0;
        mode   = 1;
        repeat (30 * OVS) put(1'b0);
        put(1'b1);
        mode = 2;
        idle_bits(15);
        mode = 0;
        check("break_count", 32'(break_pulses), 32'(3));

        send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        idle_bits(2);

        d = 8'h96;
        put_bit(1'b0, -1);
        for (int i = 0; i < 3; i++) put_bit(d[i], -1);
        repeat (OVS / 2) put(d[3]);
        rx_in = 1'b1;
        @(negedge clk);
        hard_rst_n = 1'b0;
        @(negedge clk);
        hard_rst_n = 1'b1;
        check("midrst_rx_data", 32'(rx_data), 32'(0));
        check("midrst_stop_err", 32'(stop_err), 32'(0));
        check("midrst_par_err", 32'(par_err), 32'(0));
        check("midrst_busy", 32'(busy), 32'(0));
        check("midrst_valid", 32'(data_valid), 32'(0));
        idle_bits(12);

        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        idle_bits(3);
        check("final_drained", 32'(exp_q.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_fsmd.md
Name: uart_rx_fsmd

Overview:
- UART receiver; the companion of the team's UART transmitter FSMD, using the same frame format: 1 start bit, DATA_WIDTH data bits LSB-first, optional parity bit, 1 stop bit.
- Samples the serial line at OVERSAMPLE times the baud rate, using a shared oversample tick enable.
- Recovers each data bit by majority vote around mid-bit.
- Delivers each byte with a one-cycle valid pulse and per-frame error flags to the downstream consumer.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame (5..9).
- OVERSAMPLE, 16, oversample ticks per bit (power of 2, >= 8).

Ports:
- clk  in  1  system clock.
- hard_rst_n  in  1  synchronous active-low reset.
- baud_tick  in  1  one-clk pulse at OVERSAMPLE x baud rate; all sampling advances only on this pulse.
- rx_in  in  1  serial line; idles high; asynchronous to clk.
- par_en  in  1  1 = frame carries a parity bit; latched at start-bit detection.
- par_typ  in  1  0 = even, 1 = odd; latched at start-bit detection.
- rx_data  out  DATA_WIDTH  last received data word; held until the next frame completes.
- data_valid  out  1  one-clk pulse at frame completion.
- par_err  out  1  valid with data_valid; 1 = parity mismatch.
- stop_err  out  1  valid with data_valid; 1 = stop bit sampled 0.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset: on a clk edge with hard_rst_n=0, all of the following take effect.
  - state=IDLE; sample counter and bit counter = 0.
  - rx_data=0; data_valid=0; par_err=0; stop_err=0; busy=0.
  - Synchronizer flops = 1.
  - Reset mid-frame abandons the frame silently; no data_valid is issued.
- Input path: rx_in passes through a 2-flop synchronizer clocked by clk. All logic below uses the synchronized value rx_s.
- Sample counter scnt: log2(OVERSAMPLE) bits.
  - Increments on baud_tick.
  - Wraps from OVERSAMPLE-1 to 0; each wrap advances one bit period.
  - Cleared on every state entry.
- Mid-bit point: M = OVERSAMPLE/2.
  - Samples taken at scnt = M-1, M, M+1.
  - Bit value = majority of the 3 samples, decided on the baud_tick where scnt = M+1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: stay while rx_s=1. On the first baud_tick with rx_s=0, go to START, clear scnt, latch par_en/par_typ.
  - START: at the mid-bit decision, a majority of 1 is a glitch: return to IDLE, no outputs. A majority of 0 continues. At scnt wrap, go to DATA with bcnt=0.
  - DATA:
    - Each decided bit shifts into the shift register at the MSB side, so after DATA_WIDTH bits bit0 is the first received bit.
    - At each scnt wrap, bcnt increments.
    - When bcnt = DATA_WIDTH-1 and scnt wraps: go to PARITY if par_en latched, else go to STOP.
  - PARITY:
    - Decide the parity bit.
    - par_err_int = (XOR of shift register XOR parity bit) != par_typ.
    - At scnt wrap, go to STOP.
  - STOP:
    - At the mid-bit decision: rx_data <= shift register; data_valid <= 1 for one clk; par_err <= par_err_int (0 if parity disabled); stop_err <= ~bit.
    - Go to IDLE on the same decision. The second half of the stop bit is not awaited, so a back-to-back start edge is caught.
- Output timing: data_valid, rx_data, par_err and stop_err update on the clk edge that registers the stop-bit decision.
- Error flags:
  - par_err and stop_err hold their value until the next data_valid.
  - data_valid is issued even when either flag is set.
- Break condition (line held low): the frame completes with stop_err=1. The FSM then returns to IDLE, sees rx_s=0, and re-enters START. The START glitch check passes, so break frames repeat for as long as the line stays low.
- Ticks: baud_tick=0 freezes all counters and the FSM; state never advances without a tick. Ticks are never closer than 2 clk cycles apart.

Decomposition:
- Package uart_pkg:
  - state enum: IDLE, START, DATA, PARITY, STOP.
  - Localparams for the majority sample indices.
  - Parity-type encoding constants, shared with the Tx side.
- One sub-module, rx_bit_sampler:
  - Owns the 2-flop synchronizer, scnt, the 3-sample capture and the majority vote.
  - Outputs bit_done (one-clk pulse), bit_val and period_end (scnt wrap).
  - The FSM, bit counter and shift register stay in uart_rx_fsmd.

Test Plan:
- Basic frame: par_en=0, tick every 4 clk, send 0xA5 at 16 ticks/bit -> one data_valid; rx_data=0xA5; par_err=0; stop_err=0; busy low after the pulse.
- Parity: par_en=1, par_typ=0, send 0x37 with parity bit 1 -> par_err=0. Same frame with parity bit 0 -> par_err=1, rx_data=0x37.
- Glitch and noise:
  - 5-tick low pulse on idle line -> FSM returns to IDLE; no data_valid.
  - Single-tick inversion at scnt=M on a data bit -> majority corrects it; rx_data intact.
- Back-to-back: frames 0x00, 0xFF with no idle between them (next start begins right after stop) -> two data_valid pulses, correct values, no errors.
- Framing and break:
  - Stop bit driven 0 -> stop_err=1 with data_valid.
  - Line held low for 30 bit times -> repeated data_valid with rx_data=0x00, stop_err=1.
- Reset mid-frame: assert hard_rst_n=0 for 1 clk during DATA bit 3 -> all outputs 0, no data_valid. A clean 0x5A sent afterwards -> received correctly.
